// File: rtl/cpu_ctrl_pkg.sv
// Encodings shared by the multicycle CPU control unit and the datapath mux selects.
// State values are exported on the state port, so their numbering is part of the interface.
package cpu_ctrl_pkg;

    typedef enum logic [4:0] {
        StRst       = 5'd0,
        StFetch     = 5'd1,
        StFetchWait = 5'd2,
        StDecode    = 5'd3,
        StRExec     = 5'd4,
        StRWb       = 5'd5,
        StAddiExec  = 5'd6,
        StAddiWb    = 5'd7,
        StSltWb     = 5'd8,
        StMemAddr   = 5'd9,
        StLwRd      = 5'd10,
        StLwWait    = 5'd11,
        StLwWb      = 5'd12,
        StSwWr      = 5'd13,
        StBranch    = 5'd14,
        StJump      = 5'd15,
        StLuiWb     = 5'd16,
        StExcSave   = 5'd17,
        StExcRd     = 5'd18,
        StExcWait   = 5'd19,
        StExcJump   = 5'd20
    } state_e;

    typedef enum logic {
        CauseInvalid  = 1'b0,
        CauseOverflow = 1'b1
    } cause_e;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnSlt = 6'h2A;

    localparam logic [2:0] AluLoadA = 3'b000;
    localparam logic [2:0] AluAdd   = 3'b001;
    localparam logic [2:0] AluSub   = 3'b010;
    localparam logic [2:0] AluAnd   = 3'b011;
    localparam logic [2:0] AluCmp   = 3'b111;

    localparam logic [2:0] PcSrcJump   = 3'd0;
    localparam logic [2:0] PcSrcAlu    = 3'd1;
    localparam logic [2:0] PcSrcEpc    = 3'd2;
    localparam logic [2:0] PcSrcAluOut = 3'd3;
    localparam logic [2:0] PcSrcMd     = 3'd4;

    localparam logic [2:0] MemAdrPc     = 3'd0;
    localparam logic [2:0] MemAdrAluOut = 3'd1;
    localparam logic [2:0] MemAdrA      = 3'd2;
    localparam logic [2:0] MemAdrB      = 3'd3;
    localparam logic [2:0] MemAdrExcInv = 3'd4;
    localparam logic [2:0] MemAdrExcOvf = 3'd5;

    localparam logic [1:0] SrcAPc  = 2'd0;
    localparam logic [1:0] SrcAA   = 2'd1;
    localparam logic [1:0] SrcAMdr = 2'd2;

    localparam logic [1:0] SrcBB      = 2'd0;
    localparam logic [1:0] SrcBImm    = 2'd1;
    localparam logic [1:0] SrcBImmSl2 = 2'd2;
    localparam logic [1:0] SrcBFour   = 2'd3;

    localparam logic [1:0] WrRt = 2'd0;
    localparam logic [1:0] WrRd = 2'd1;

    localparam logic [2:0] WdAluOut = 3'd0;
    localparam logic [2:0] WdMem    = 3'd1;
    localparam logic [2:0] WdSl16   = 3'd2;
    localparam logic [2:0] WdExt1   = 3'd6;

    localparam logic [1:0] MdWord   = 2'd0;
    localparam logic [1:0] MdByteZx = 2'd2;

    function automatic logic [2:0] alu_op_for_funct(input logic [5:0] funct);
        case (funct)
            FnSub:   return AluSub;
            FnAnd:   return AluAnd;
            default: return AluAdd;
        endcase
    endfunction

endpackage

// File: rtl/control_unit.sv
// Multicycle sequencer: decodes IR opcode/funct and ALU flags into Moore-style datapath
// controls, including invalid-opcode and overflow exception entry.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       O,
    input  logic       N,
    input  logic       Z,
    input  logic       ET,
    input  logic       GT,
    input  logic       LT,
    output logic       PCWrite,
    output logic       MemWrRd,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       AB_w,
    output logic       MDWrite,
    output logic       EPCWrite,
    output logic       ALUOutWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] PCSource,
    output logic [2:0] MemAdrsSrc,
    output logic [1:0] WriteIn,
    output logic [2:0] WriteDataSrc,
    output logic [1:0] MDControl,
    output logic [1:0] WDControl,
    output logic [4:0] state
);

    state_e state_q, state_d;
    cause_e cause_q, cause_d;

    // Only O and ET steer the sequence; the remaining flags are part of the datapath bundle.
    logic unused_flags;
    assign unused_flags = ^{N, Z, GT, LT};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StRst;
            cause_q <= CauseInvalid;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Next-state; cause_d changes only on transitions into StExcSave.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            StRst:       state_d = StFetch;
            StFetch:     state_d = StFetchWait;
            StFetchWait: state_d = StDecode;
            StDecode: begin
                unique case (Opcode)
                    OpRType: begin
                        unique case (Funct)
                            FnAdd, FnSub, FnAnd: state_d = StRExec;
                            FnSlt:               state_d = StSltWb;
                            default: begin
                                state_d = StExcSave;
                                cause_d = CauseInvalid;
                            end
                        endcase
                    end
                    OpAddi:       state_d = StAddiExec;
                    OpLw, OpSw:   state_d = StMemAddr;
                    OpBeq, OpBne: state_d = StBranch;
                    OpJ:          state_d = StJump;
                    OpLui:        state_d = StLuiWb;
                    default: begin
                        state_d = StExcSave;
                        cause_d = CauseInvalid;
                    end
                endcase
            end
            StRExec: begin
                if (O && (Funct == FnAdd || Funct == FnSub)) begin
                    state_d = StExcSave;
                    cause_d = CauseOverflow;
                end else begin
                    state_d = StRWb;
                end
            end
            StAddiExec: begin
                if (O) begin
                    state_d = StExcSave;
                    cause_d = CauseOverflow;
                end else begin
                    state_d = StAddiWb;
                end
            end
            StMemAddr:  state_d = (Opcode == OpLw) ? StLwRd : StSwWr;
            StLwRd:     state_d = StLwWait;
            StLwWait:   state_d = StLwWb;
            StExcSave:  state_d = StExcRd;
            StExcRd:    state_d = StExcWait;
            StExcWait:  state_d = StExcJump;
            StRWb, StAddiWb, StSltWb, StLwWb, StSwWr, StBranch, StJump, StLuiWb, StExcJump:
                state_d = StFetch;
            default:    state_d = StRst;
        endcase
    end

    always_comb begin
        PCWrite      = 1'b0;
        MemWrRd      = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        AB_w         = 1'b0;
        MDWrite      = 1'b0;
        EPCWrite     = 1'b0;
        ALUOutWrite  = 1'b0;
        ALUSrcA      = SrcAPc;
        ALUSrcB      = SrcBB;
        ALUControl   = AluLoadA;
        PCSource     = PcSrcJump;
        MemAdrsSrc   = MemAdrPc;
        WriteIn      = WrRt;
        WriteDataSrc = WdAluOut;
        MDControl    = MdWord;
        WDControl    = MdWord;
        unique case (state_q)
            StFetch: begin
                MemAdrsSrc = MemAdrPc;
                ALUSrcA    = SrcAPc;
                ALUSrcB    = SrcBFour;
                ALUControl = AluAdd;
            end
            StFetchWait: begin
                MemAdrsSrc = MemAdrPc;
                ALUSrcA    = SrcAPc;
                ALUSrcB    = SrcBFour;
                ALUControl = AluAdd;
                IRWrite    = 1'b1;
                PCSource   = PcSrcAlu;
                PCWrite    = 1'b1;
            end
            StDecode: begin
                AB_w        = 1'b1;
                ALUSrcA     = SrcAPc;
                ALUSrcB     = SrcBImmSl2;
                ALUControl  = AluAdd;
                ALUOutWrite = 1'b1;
            end
            StRExec: begin
                ALUSrcA     = SrcAA;
                ALUSrcB     = SrcBB;
                ALUControl  = alu_op_for_funct(Funct);
                ALUOutWrite = 1'b1;
            end
            StRWb: begin
                WriteIn      = WrRd;
                WriteDataSrc = WdAluOut;
                RegWrite     = 1'b1;
            end
            StAddiExec, StMemAddr: begin
                ALUSrcA     = SrcAA;
                ALUSrcB     = SrcBImm;
                ALUControl  = AluAdd;
                ALUOutWrite = 1'b1;
            end
            StAddiWb: begin
                WriteIn      = WrRt;
                WriteDataSrc = WdAluOut;
                RegWrite     = 1'b1;
            end
            StSltWb: begin
                ALUSrcA      = SrcAA;
                ALUSrcB      = SrcBB;
                ALUControl   = AluCmp;
                WriteIn      = WrRd;
                WriteDataSrc = WdExt1;
                RegWrite     = 1'b1;
            end
            StLwRd: MemAdrsSrc = MemAdrAluOut;
            StLwWait: begin
                MemAdrsSrc = MemAdrAluOut;
                MDWrite    = 1'b1;
            end
            StLwWb: begin
                MDControl    = MdWord;
                WriteIn      = WrRt;
                WriteDataSrc = WdMem;
                RegWrite     = 1'b1;
            end
            StSwWr: begin
                MemAdrsSrc = MemAdrAluOut;
                WDControl  = MdWord;
                MemWrRd    = 1'b1;
            end
            StBranch: begin
                ALUSrcA    = SrcAA;
                ALUSrcB    = SrcBB;
                ALUControl = AluCmp;
                PCSource   = PcSrcAluOut;
                // Target was precomputed into ALUOut during decode.
                PCWrite    = ((Opcode == OpBeq) && ET) || ((Opcode == OpBne) && !ET);
            end
            StJump: begin
                PCSource = PcSrcJump;
                PCWrite  = 1'b1;
            end
            StLuiWb: begin
                WriteIn      = WrRt;
                WriteDataSrc = WdSl16;
                RegWrite     = 1'b1;
            end
            StExcSave: begin
                // PC already advanced by 4; subtract it back to get the faulting address.
                ALUSrcA    = SrcAPc;
                ALUSrcB    = SrcBFour;
                ALUControl = AluSub;
                EPCWrite   = 1'b1;
            end
            StExcRd: begin
                MemAdrsSrc = (cause_q == CauseOverflow) ? MemAdrExcOvf : MemAdrExcInv;
            end
            StExcWait: begin
                MemAdrsSrc = (cause_q == CauseOverflow) ? MemAdrExcOvf : MemAdrExcInv;
                MDWrite    = 1'b1;
            end
            StExcJump: begin
                MDControl = MdByteZx;
                PCSource  = PcSrcMd;
                PCWrite   = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: table of whole-instruction runs plus hand sequences
// for reset, exception and mid-instruction asynchronous reset behaviour.
module tb_control_unit;
    import cpu_ctrl_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] Opcode = '0;
    logic [5:0] Funct = '0;
    logic       O = 1'b0, N = 1'b0, Z = 1'b0, ET = 1'b0, GT = 1'b0, LT = 1'b0;
    logic       PCWrite, MemWrRd, IRWrite, RegWrite, AB_w, MDWrite, EPCWrite, ALUOutWrite;
    logic [1:0] ALUSrcA, ALUSrcB, WriteIn, MDControl, WDControl;
    logic [2:0] ALUControl, PCSource, MemAdrsSrc, WriteDataSrc;
    logic [4:0] state;

    control_unit dut (
        .clock(clock), .reset(reset), .Opcode(Opcode), .Funct(Funct),
        .O(O), .N(N), .Z(Z), .ET(ET), .GT(GT), .LT(LT),
        .PCWrite(PCWrite), .MemWrRd(MemWrRd), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .AB_w(AB_w), .MDWrite(MDWrite), .EPCWrite(EPCWrite), .ALUOutWrite(ALUOutWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSource(PCSource),
        .MemAdrsSrc(MemAdrsSrc), .WriteIn(WriteIn), .WriteDataSrc(WriteDataSrc),
        .MDControl(MDControl), .WDControl(WDControl), .state(state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0] st;
        logic       pcw, memwr, irw, regw, abw, mdw, epcw, aluoutw;
        logic [1:0] srca, srcb;
        logic [2:0] aluc, pcsrc, madr;
        logic [1:0] wrin;
        logic [2:0] wds;
        logic [1:0] mdc, wdc;
    } smp_t;

    smp_t        cur;
    logic [29:0] outs;
    assign cur = {state, PCWrite, MemWrRd, IRWrite, RegWrite, AB_w, MDWrite, EPCWrite,
                  ALUOutWrite, ALUSrcA, ALUSrcB, ALUControl, PCSource, MemAdrsSrc, WriteIn,
                  WriteDataSrc, MDControl, WDControl};
    assign outs = cur[29:0];

    typedef struct {
        string            name;
        logic [5:0]       op, fn;
        logic             o, et;
        int               len;
        logic [0:7][4:0]  path;
        int               regw, pcw, memw, mdw, epcw;
    } vec_t;

    vec_t vq[$];
    smp_t trace[20];
    int   total = 0;
    int   passed = 0;

    localparam logic [14:0] FD  = {StFetch, StFetchWait, StDecode};
    localparam logic [19:0] EXC = {StExcSave, StExcRd, StExcWait, StExcJump};

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else passed++;
    endtask

    function automatic vec_t mk(input string name, input logic [5:0] op, fn, input logic o, et,
                                input int len, input logic [39:0] path,
                                input int regw, pcw, memw, mdw, epcw);
        vec_t v;
        v.name = name; v.op = op; v.fn = fn; v.o = o; v.et = et; v.len = len;
        v.path = path; v.regw = regw; v.pcw = pcw; v.memw = memw; v.mdw = mdw; v.epcw = epcw;
        return v;
    endfunction

    // Called at a negedge with the DUT in FETCH; returns cycles until the next FETCH.
    task automatic run(input logic [5:0] op, fn, input logic o, et, output int n);
        Opcode = op; Funct = fn; O = o; ET = et;
        n = 0;
        do begin
            trace[n] = cur;
            n++;
            @(negedge clock);
        end while (cur.st != StFetch && n < 20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int n, mism, rw, pw, mw, md, ep;

        vq.push_back(mk("add",      OpRType, FnAdd, 0, 0, 5, {FD, StRExec, StRWb, 15'd0},       1, 1, 0, 0, 0));
        vq.push_back(mk("sub",      OpRType, FnSub, 0, 0, 5, {FD, StRExec, StRWb, 15'd0},       1, 1, 0, 0, 0));
        vq.push_back(mk("and_o1",   OpRType, FnAnd, 1, 0, 5, {FD, StRExec, StRWb, 15'd0},       1, 1, 0, 0, 0));
        vq.push_back(mk("add_ovf",  OpRType, FnAdd, 1, 0, 8, {FD, StRExec, EXC},                0, 2, 0, 1, 1));
        vq.push_back(mk("sub_ovf",  OpRType, FnSub, 1, 0, 8, {FD, StRExec, EXC},                0, 2, 0, 1, 1));
        vq.push_back(mk("slt",      OpRType, FnSlt, 1, 0, 4, {FD, StSltWb, 20'd0},              1, 1, 0, 0, 0));
        vq.push_back(mk("bad_fn",   OpRType, 6'h01, 0, 0, 7, {FD, EXC, 5'd0},                   0, 2, 0, 1, 1));
        vq.push_back(mk("addi",     OpAddi,  6'h3F, 0, 0, 5, {FD, StAddiExec, StAddiWb, 15'd0}, 1, 1, 0, 0, 0));
        vq.push_back(mk("addi_ovf", OpAddi,  6'h00, 1, 0, 8, {FD, StAddiExec, EXC},             0, 2, 0, 1, 1));
        vq.push_back(mk("lw",       OpLw,    6'h00, 1, 0, 7,
                        {FD, StMemAddr, StLwRd, StLwWait, StLwWb, 5'd0},                        1, 1, 0, 1, 0));
        vq.push_back(mk("sw",       OpSw,    6'h00, 0, 1, 5, {FD, StMemAddr, StSwWr, 15'd0},    0, 1, 1, 0, 0));
        vq.push_back(mk("beq_t",    OpBeq,   6'h00, 0, 1, 4, {FD, StBranch, 20'd0},             0, 2, 0, 0, 0));
        vq.push_back(mk("beq_nt",   OpBeq,   6'h00, 0, 0, 4, {FD, StBranch, 20'd0},             0, 1, 0, 0, 0));
        vq.push_back(mk("bne_et1",  OpBne,   6'h00, 0, 1, 4, {FD, StBranch, 20'd0},             0, 1, 0, 0, 0));
        vq.push_back(mk("bne_et0",  OpBne,   6'h00, 0, 0, 4, {FD, StBranch, 20'd0},             0, 2, 0, 0, 0));
        vq.push_back(mk("j",        OpJ,     6'h00, 1, 0, 4, {FD, StJump, 20'd0},               0, 2, 0, 0, 0));
        vq.push_back(mk("lui",      OpLui,   6'h00, 0, 0, 4, {FD, StLuiWb, 20'd0},              1, 1, 0, 0, 0));
        vq.push_back(mk("op3f",     6'h3F,   6'h20, 0, 0, 7, {FD, EXC, 5'd0},                   0, 2, 0, 1, 1));

        // Reset held, then released
        Opcode = OpLui;
        repeat (2) @(negedge clock);
        chk("rst_state", int'(cur.st), int'(StRst));
        chk("rst_outs", int'(outs), 0);
        reset = 1'b1;
        trace[0] = cur;
        for (int i = 1; i < 4; i++) begin
            @(negedge clock);
            trace[i] = cur;
        end
        chk("rst_seq_fetch", int'(trace[1].st), int'(StFetch));
        chk("rst_seq_fwait", int'(trace[2].st), int'(StFetchWait));
        chk("rst_seq_decode", int'(trace[3].st), int'(StDecode));
        pw = 0;
        for (int i = 0; i < 4; i++) pw += int'(trace[i].pcw);
        chk("rst_pcw_count", pw, 1);
        chk("rst_pcw_fwait", int'(trace[2].pcw), 1);
        repeat (2) @(negedge clock);
        chk("rst_to_fetch", int'(cur.st), int'(StFetch));

        foreach (vq[k]) begin
            run(vq[k].op, vq[k].fn, vq[k].o, vq[k].et, n);
            chk({vq[k].name, "_len"}, n, vq[k].len);
            mism = 0; rw = 0; pw = 0; mw = 0; md = 0; ep = 0;
            for (int i = 0; i < n; i++) begin
                if (i < 8 && trace[i].st != vq[k].path[i]) mism++;
                rw += int'(trace[i].regw);
                pw += int'(trace[i].pcw);
                mw += int'(trace[i].memwr);
                md += int'(trace[i].mdw);
                ep += int'(trace[i].epcw);
            end
            chk({vq[k].name, "_path_mismatches"}, mism, 0);
            chk({vq[k].name, "_regwrite"}, rw, vq[k].regw);
            chk({vq[k].name, "_pcwrite"}, pw, vq[k].pcw);
            chk({vq[k].name, "_memwr"}, mw, vq[k].memw);
            chk({vq[k].name, "_mdwrite"}, md, vq[k].mdw);
            chk({vq[k].name, "_epcwrite"}, ep, vq[k].epcw);
        end

        // Per-state output detail
        run(OpRType, FnAdd, 0, 0, n);
        chk("fwait_irwrite", int'(trace[1].irw), 1);
        chk("fwait_pcsource", int'(trace[1].pcsrc), 1);
        chk("fwait_srcb", int'(trace[1].srcb), 3);
        chk("decode_abw", int'(trace[2].abw), 1);
        chk("decode_srcb", int'(trace[2].srcb), 2);
        chk("decode_aluoutw", int'(trace[2].aluoutw), 1);
        chk("rexec_add_aluc", int'(trace[3].aluc), 1);
        chk("rexec_srca", int'(trace[3].srca), 1);
        chk("rwb_writein", int'(trace[4].wrin), 1);
        chk("rwb_wds", int'(trace[4].wds), 0);
        run(OpRType, FnSub, 0, 0, n);
        chk("rexec_sub_aluc", int'(trace[3].aluc), 2);
        run(OpRType, FnAnd, 0, 0, n);
        chk("rexec_and_aluc", int'(trace[3].aluc), 3);

        run(OpRType, FnAdd, 1, 0, n);
        chk("ovf_save_aluc", int'(trace[4].aluc), 2);
        chk("ovf_save_srcb", int'(trace[4].srcb), 3);
        chk("ovf_rd_madr", int'(trace[5].madr), 5);
        chk("ovf_wait_madr", int'(trace[6].madr), 5);

        run(6'h3F, 6'h00, 0, 0, n);
        chk("inv_rd_madr", int'(trace[4].madr), 4);
        chk("inv_wait_madr", int'(trace[5].madr), 4);
        chk("inv_jump_pcsource", int'(trace[6].pcsrc), 4);
        chk("inv_jump_mdc", int'(trace[6].mdc), 2);

        run(OpLw, 6'h00, 0, 0, n);
        chk("lw_rd_madr", int'(trace[4].madr), 1);
        chk("lw_rd_mdw", int'(trace[4].mdw), 0);
        chk("lw_wait_madr", int'(trace[5].madr), 1);
        chk("lw_wait_mdw", int'(trace[5].mdw), 1);
        chk("lw_wb_wds", int'(trace[6].wds), 1);
        chk("lw_wb_regw", int'(trace[6].regw), 1);

        run(OpSw, 6'h00, 0, 0, n);
        chk("sw_madr", int'(trace[4].madr), 1);
        run(OpBeq, 6'h00, 0, 1, n);
        chk("beq_pcsource", int'(trace[3].pcsrc), 3);
        chk("beq_aluc", int'(trace[3].aluc), 7);
        run(OpRType, FnSlt, 0, 0, n);
        chk("slt_wds", int'(trace[3].wds), 6);
        chk("slt_writein", int'(trace[3].wrin), 1);
        run(OpLui, 6'h00, 0, 0, n);
        chk("lui_wds", int'(trace[3].wds), 2);

        // Asynchronous reset in LW_WAIT
        Opcode = OpLw; Funct = 6'h00; O = 1'b0;
        repeat (5) @(negedge clock);
        chk("lw_reach_wait", int'(cur.st), int'(StLwWait));
        #2 reset = 1'b0;
        #1;
        chk("async_rst_state", int'(cur.st), int'(StRst));
        chk("async_rst_outs", int'(outs), 0);
        @(negedge clock);
        chk("async_rst_hold", int'(cur.st), int'(StRst));
        chk("async_rst_regw", int'(cur.regw), 0);
        Opcode = OpSw;
        reset = 1'b1;
        @(negedge clock);
        chk("recover_fetch", int'(cur.st), int'(StFetch));
        run(OpSw, 6'h00, 0, 0, n);
        rw = 0;
        for (int i = 0; i < n; i++) rw += int'(trace[i].regw);
        chk("recover_regw", rw, 0);
        chk("recover_len", n, 5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
